// File: rtl/settings_pkg.sv
// Shared types and flash CSR layout for the settings store.
package settings_pkg;

    typedef enum logic [3:0] {
        LOAD_RD, LOAD_WAIT, IDLE, UNPROT, ERASE, ERASE_POLL, PROG_WR, PROG_POLL, REPROT
    } state_t;

    typedef enum logic [1:0] {P_IDLE, P_RD, P_CHK} poll_state_t;

    localparam logic CSR_STATUS = 1'b0;
    localparam logic CSR_CTRL   = 1'b1;

    localparam int unsigned ST_BUSY_MSB = 1;
    localparam int unsigned ST_WRITE_OK = 3;
    localparam int unsigned ST_ERASE_OK = 4;

    localparam int unsigned WP_BASE = 22;
    localparam int unsigned SE_MSB  = 22;
    localparam int unsigned SE_LSB  = 20;

    // Control word: all protect bits set and no erase, optionally unprotecting/erasing one sector.
    function automatic logic [31:0] ctrl_word(input logic [2:0] sector, input logic unprot,
                                              input logic erase);
        logic [31:0] w;
        w = '1;
        if (unprot) w[5'(WP_BASE) + 5'(sector)] = 1'b0;
        if (erase) w[SE_MSB:SE_LSB] = sector;
        return w;
    endfunction

endpackage

// File: rtl/settings_store_if.sv
// Avalon-MM data and CSR ports of the on-chip flash.
interface settings_store_if;
    logic [11:0] avmm_data_addr;
    logic        avmm_data_read;
    logic        avmm_data_write;
    logic [31:0] avmm_data_writedata;
    logic [1:0]  avmm_data_burstcount;
    logic [31:0] avmm_data_readdata;
    logic        avmm_data_waitrequest;
    logic        avmm_data_readdatavalid;
    logic        avmm_csr_addr;
    logic        avmm_csr_read;
    logic        avmm_csr_write;
    logic [31:0] avmm_csr_writedata;
    logic [31:0] avmm_csr_readdata;

    modport master (
        output avmm_data_addr, avmm_data_read, avmm_data_write, avmm_data_writedata,
               avmm_data_burstcount, avmm_csr_addr, avmm_csr_read, avmm_csr_write,
               avmm_csr_writedata,
        input  avmm_data_readdata, avmm_data_waitrequest, avmm_data_readdatavalid,
               avmm_csr_readdata
    );

    modport slave (
        input  avmm_data_addr, avmm_data_read, avmm_data_write, avmm_data_writedata,
               avmm_data_burstcount, avmm_csr_addr, avmm_csr_read, avmm_csr_write,
               avmm_csr_writedata,
        output avmm_data_readdata, avmm_data_waitrequest, avmm_data_readdatavalid,
               avmm_csr_readdata
    );
endinterface

// File: rtl/settings_poll.sv
// Polls the flash status register until idle, then reports the relevant success bit.
module settings_poll
    import settings_pkg::*;
#(
    parameter logic [15:0] POLL_LIMIT = 16'hFFFF
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        i_start,
    input  logic        i_erase,
    input  logic [31:0] i_status,
    output logic        o_rd,
    output logic        o_done,
    output logic        o_ok
);

    poll_state_t r_state, w_state;
    logic [15:0] r_cnt, w_cnt;
    logic        r_rd, w_rd, r_done, w_done, r_ok, w_ok;
    logic        w_busy;
    logic        w_unused_status;

    assign w_busy          = |i_status[ST_BUSY_MSB:0];
    assign w_unused_status = ^{i_status[31:ST_ERASE_OK+1], i_status[ST_WRITE_OK-1:ST_BUSY_MSB+1]};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= P_IDLE;
            r_cnt   <= '0;
            r_rd    <= 1'b0;
            r_done  <= 1'b0;
            r_ok    <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_rd    <= w_rd;
            r_done  <= w_done;
            r_ok    <= w_ok;
        end
    end

    // Read status is returned the cycle after the read strobe.
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_rd    = 1'b0;
        w_done  = 1'b0;
        w_ok    = r_ok;
        unique case (r_state)
            P_IDLE: if (i_start) begin
                w_state = P_RD;
                w_rd    = 1'b1;
                w_cnt   = '0;
            end
            P_RD: w_state = P_CHK;
            P_CHK: begin
                if (!w_busy) begin
                    w_state = P_IDLE;
                    w_done  = 1'b1;
                    w_ok    = i_erase ? i_status[ST_ERASE_OK] : i_status[ST_WRITE_OK];
                end else if (r_cnt == POLL_LIMIT - 16'd1) begin
                    w_state = P_IDLE;
                    w_done  = 1'b1;
                    w_ok    = 1'b0;
                end else begin
                    w_state = P_RD;
                    w_rd    = 1'b1;
                    w_cnt   = r_cnt + 16'd1;
                end
            end
            default: w_state = P_IDLE;
        endcase
    end

    assign o_rd   = r_rd;
    assign o_done = r_done;
    assign o_ok   = r_ok;

endmodule

// File: rtl/settings_store.sv
// Settings cache loaded from UFM at reset and written back (erase + program) on request.
module settings_store
    import settings_pkg::*;
#(
    parameter int unsigned NUM_WORDS  = 8,
    parameter logic [11:0] BASE_ADDR  = 12'h000,
    parameter int unsigned SECTOR     = 1,
    parameter logic [31:0] MAGIC      = 32'hC64D_0001,
    parameter logic [15:0] POLL_LIMIT = 16'hFFFF,
    localparam int unsigned IDX_W     = $clog2(NUM_WORDS),
    localparam int unsigned CNT_W     = $clog2(NUM_WORDS + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic [31:0]      cfg_wdata,
    input  logic             cfg_we,
    output logic [31:0]      cfg_rdata,
    input  logic             save,
    output logic             ready,
    output logic             blank,
    output logic             error,
    settings_store_if.master flash
);

    state_t           r_state, w_state;
    logic [CNT_W-1:0] r_idx, w_idx;
    logic [31:0]      r_cache [NUM_WORDS];
    logic [31:0]      r_cfg_rdata;
    logic             r_rd, w_rd, r_wr, w_wr;
    logic [11:0]      r_addr, w_addr;
    logic [31:0]      r_wdata, w_wdata;
    logic             r_csr_wr, w_csr_wr, r_csr_addr, w_csr_addr;
    logic [31:0]      r_csr_wdata, w_csr_wdata;
    logic             r_ready, w_ready, r_blank, w_blank, r_error, w_error;
    logic             r_save_pend, w_save_pend;
    logic             w_in_load, w_load_we;
    logic             w_poll_start, w_poll_rd, w_poll_done, w_poll_ok;

    assign w_in_load = (r_state == LOAD_RD) || (r_state == LOAD_WAIT);

    settings_poll #(.POLL_LIMIT(POLL_LIMIT)) u_poll (
        .clock    (clock),
        .reset_n  (reset_n),
        .i_start  (w_poll_start),
        .i_erase  (r_state == ERASE_POLL),
        .i_status (flash.avmm_csr_readdata),
        .o_rd     (w_poll_rd),
        .o_done   (w_poll_done),
        .o_ok     (w_poll_ok)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= LOAD_RD;
            r_idx       <= '0;
            r_rd        <= 1'b0;
            r_wr        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_csr_wr    <= 1'b0;
            r_csr_addr  <= 1'b0;
            r_csr_wdata <= '0;
            r_ready     <= 1'b0;
            r_blank     <= 1'b0;
            r_error     <= 1'b0;
            r_save_pend <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_idx       <= w_idx;
            r_rd        <= w_rd;
            r_wr        <= w_wr;
            r_addr      <= w_addr;
            r_wdata     <= w_wdata;
            r_csr_wr    <= w_csr_wr;
            r_csr_addr  <= w_csr_addr;
            r_csr_wdata <= w_csr_wdata;
            r_ready     <= w_ready;
            r_blank     <= w_blank;
            r_error     <= w_error;
            r_save_pend <= w_save_pend;
        end
    end

    // Flash words are read from the live cache as each one is programmed.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(NUM_WORDS); i++) r_cache[i] <= '0;
            r_cfg_rdata <= '0;
        end else begin
            if (w_load_we)
                r_cache[IDX_W'(r_idx - CNT_W'(1))] <= flash.avmm_data_readdata;
            else if (cfg_we && !w_in_load)
                r_cache[cfg_idx] <= cfg_wdata;
            r_cfg_rdata <= r_cache[cfg_idx];
        end
    end

    always_comb begin
        w_state      = r_state;
        w_idx        = r_idx;
        w_rd         = r_rd;
        w_wr         = r_wr;
        w_addr       = r_addr;
        w_wdata      = r_wdata;
        w_csr_wr     = 1'b0;
        w_csr_addr   = r_csr_addr;
        w_csr_wdata  = r_csr_wdata;
        w_blank      = r_blank;
        w_error      = r_error;
        w_save_pend  = r_save_pend | (save & ~w_in_load);
        w_poll_start = 1'b0;
        w_load_we    = 1'b0;
        unique case (r_state)
            LOAD_RD: begin
                if (!r_rd) begin
                    w_rd   = 1'b1;
                    w_addr = BASE_ADDR + 12'(r_idx);
                end else if (!flash.avmm_data_waitrequest) begin
                    w_rd    = 1'b0;
                    w_state = LOAD_WAIT;
                end
            end
            LOAD_WAIT: if (flash.avmm_data_readdatavalid) begin
                if (r_idx == '0 && flash.avmm_data_readdata != MAGIC) begin
                    w_blank = 1'b1;
                    w_state = IDLE;
                end else begin
                    w_load_we = (r_idx != '0);
                    if (r_idx == CNT_W'(NUM_WORDS)) begin
                        w_blank = 1'b0;
                        w_state = IDLE;
                    end else begin
                        w_idx   = r_idx + CNT_W'(1);
                        w_state = LOAD_RD;
                    end
                end
            end
            IDLE: if (w_save_pend) begin
                w_save_pend = 1'b0;
                w_error     = 1'b0;
                w_state     = UNPROT;
                w_csr_wr    = 1'b1;
                w_csr_addr  = CSR_CTRL;
                w_csr_wdata = ctrl_word(3'(SECTOR), 1'b1, 1'b0);
            end
            UNPROT: begin
                w_state     = ERASE;
                w_csr_wr    = 1'b1;
                w_csr_wdata = ctrl_word(3'(SECTOR), 1'b1, 1'b1);
            end
            ERASE: begin
                w_state      = ERASE_POLL;
                w_csr_addr   = CSR_STATUS;
                w_poll_start = 1'b1;
            end
            ERASE_POLL: if (w_poll_done) begin
                if (w_poll_ok) begin
                    w_state = PROG_WR;
                    w_idx   = '0;
                    w_wr    = 1'b1;
                    w_addr  = BASE_ADDR;
                    w_wdata = MAGIC;
                end else begin
                    w_error     = 1'b1;
                    w_state     = REPROT;
                    w_csr_wr    = 1'b1;
                    w_csr_addr  = CSR_CTRL;
                    w_csr_wdata = ctrl_word(3'(SECTOR), 1'b0, 1'b0);
                end
            end
            PROG_WR: if (!flash.avmm_data_waitrequest) begin
                w_wr         = 1'b0;
                w_state      = PROG_POLL;
                w_poll_start = 1'b1;
            end
            PROG_POLL: if (w_poll_done) begin
                if (w_poll_ok && r_idx != CNT_W'(NUM_WORDS)) begin
                    w_idx   = r_idx + CNT_W'(1);
                    w_state = PROG_WR;
                    w_wr    = 1'b1;
                    w_addr  = BASE_ADDR + 12'(r_idx) + 12'd1;
                    w_wdata = r_cache[IDX_W'(r_idx)];
                end else begin
                    w_error     = r_error | ~w_poll_ok;
                    w_state     = REPROT;
                    w_csr_wr    = 1'b1;
                    w_csr_addr  = CSR_CTRL;
                    w_csr_wdata = ctrl_word(3'(SECTOR), 1'b0, 1'b0);
                end
            end
            REPROT: begin
                w_state = IDLE;
                w_blank = 1'b0;
            end
            default: w_state = LOAD_RD;
        endcase
        w_ready = (w_state == IDLE);
    end

    assign cfg_rdata                  = r_cfg_rdata;
    assign ready                      = r_ready;
    assign blank                      = r_blank;
    assign error                      = r_error;
    assign flash.avmm_data_addr       = r_addr;
    assign flash.avmm_data_read       = r_rd;
    assign flash.avmm_data_write      = r_wr;
    assign flash.avmm_data_writedata  = r_wdata;
    assign flash.avmm_data_burstcount = 2'd1;
    assign flash.avmm_csr_addr        = r_csr_addr;
    assign flash.avmm_csr_read        = w_poll_rd;
    assign flash.avmm_csr_write       = r_csr_wr;
    assign flash.avmm_csr_writedata   = r_csr_wdata;

endmodule

// File: tb/tb_settings_store.sv
// Directed bench for settings_store with a small behavioural UFM model.
module tb_settings_store;

    localparam logic [31:0] MAGIC = 32'hC64D_0001;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  cfg_idx;
    logic [31:0] cfg_wdata, cfg_rdata;
    logic        cfg_we, save, ready, blank, error;

    always #5 clock = ~clock;

    settings_store_if flash_if();

    settings_store #(.POLL_LIMIT(16'd40)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .cfg_idx   (cfg_idx),
        .cfg_wdata (cfg_wdata),
        .cfg_we    (cfg_we),
        .cfg_rdata (cfg_rdata),
        .save      (save),
        .ready     (ready),
        .blank     (blank),
        .error     (error),
        .flash     (flash_if)
    );

    // Flash model state and bench controls
    logic [31:0] mem [16];
    int          wait_n = 0, img_mode = 0, wcnt = 0, busy_cnt = 0;
    bit          erase_ok_cfg = 1'b1, stuck_busy = 1'b0;
    int          stable_err = 0, csr_bad = 0, nreads = 0, nwrites = 0, nerase = 0;
    logic [11:0] held_addr;
    logic [31:0] held_data, last_ctrl, erase_word, pend_d, status;
    logic [2:0]  erase_sector;
    logic [3:0]  pend_a;
    logic        pend_v, erase_res;

    assign flash_if.avmm_data_waitrequest =
        (flash_if.avmm_data_read | flash_if.avmm_data_write) && (wcnt < wait_n);
    assign status = {27'd0, erase_res, 1'b1, 1'b0, (busy_cnt != 0 || stuck_busy) ? 2'b01 : 2'b00};

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            flash_if.avmm_data_readdatavalid <= 1'b0;
            flash_if.avmm_data_readdata      <= '0;
            flash_if.avmm_csr_readdata       <= '0;
            wcnt      <= 0;
            busy_cnt  <= 0;
            pend_v    <= 1'b0;
            erase_res <= 1'b0;
            for (int k = 0; k < 16; k++) begin
                if (img_mode == 0) mem[k] <= (k == 0) ? MAGIC : ((k <= 8) ? 32'(k) : '1);
                else if (img_mode == 1) mem[k] <= '1;
            end
        end else begin
            flash_if.avmm_data_readdatavalid <= 1'b0;
            if (flash_if.avmm_data_read | flash_if.avmm_data_write) begin
                if (wcnt == 0) begin
                    held_addr <= flash_if.avmm_data_addr;
                    held_data <= flash_if.avmm_data_writedata;
                end else if (flash_if.avmm_data_addr != held_addr ||
                             (flash_if.avmm_data_write && flash_if.avmm_data_writedata != held_data))
                    stable_err <= stable_err + 1;
                wcnt <= flash_if.avmm_data_waitrequest ? wcnt + 1 : 0;
            end
            if (flash_if.avmm_data_read && !flash_if.avmm_data_waitrequest) begin
                flash_if.avmm_data_readdata      <= mem[flash_if.avmm_data_addr[3:0]];
                flash_if.avmm_data_readdatavalid <= 1'b1;
                nreads <= nreads + 1;
            end
            if (flash_if.avmm_data_write && !flash_if.avmm_data_waitrequest) begin
                pend_v   <= 1'b1;
                pend_a   <= flash_if.avmm_data_addr[3:0];
                pend_d   <= flash_if.avmm_data_writedata;
                busy_cnt <= 3;
                nwrites  <= nwrites + 1;
            end else if (busy_cnt != 0 && !stuck_busy) begin
                busy_cnt <= busy_cnt - 1;
                if (busy_cnt == 1 && pend_v) begin
                    mem[pend_a] <= pend_d;
                    pend_v      <= 1'b0;
                end
            end
            if (flash_if.avmm_csr_write) begin
                last_ctrl <= flash_if.avmm_csr_writedata;
                if (flash_if.avmm_csr_addr && flash_if.avmm_csr_writedata[22:20] != 3'b111) begin
                    nerase       <= nerase + 1;
                    erase_word   <= flash_if.avmm_csr_writedata;
                    erase_sector <= flash_if.avmm_csr_writedata[22:20];
                    erase_res    <= erase_ok_cfg;
                    busy_cnt     <= 4;
                    if (erase_ok_cfg) for (int k = 0; k < 16; k++) mem[k] <= '1;
                end
            end
            if (flash_if.avmm_csr_read) begin
                flash_if.avmm_csr_readdata <= status;
                if (flash_if.avmm_csr_addr) csr_bad <= csr_bad + 1;
            end
        end
    end

    int n_checks = 0, n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset(input int mode);
        img_mode = mode;
        reset_n  = 1'b0;
        repeat (3) @(negedge clock);
        reset_n  = 1'b1;
    endtask

    task automatic wait_ready(input string tag, input int max);
        int n = 0;
        while (!ready && n < max) begin
            @(negedge clock);
            n++;
        end
        check_eq(tag, 32'(ready), 32'd1);
    endtask

    task automatic pulse_save();
        @(negedge clock) save = 1'b1;
        @(negedge clock) save = 1'b0;
    endtask

    task automatic read_cfg(input logic [2:0] idx, output logic [31:0] data);
        @(negedge clock) cfg_idx = idx;
        @(negedge clock) data = cfg_rdata;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        int r0, w0, e0, n;
        cfg_idx = '0; cfg_wdata = '0; cfg_we = 1'b0; save = 1'b0;

        // Reset values, then load of a valid image
        img_mode = 0;
        repeat (2) @(negedge clock);
        check_eq("rst_ready", 32'(ready), 0);
        check_eq("rst_blank", 32'(blank), 0);
        check_eq("rst_error", 32'(error), 0);
        check_eq("rst_rdata", cfg_rdata, 0);
        check_eq("rst_rd", 32'(flash_if.avmm_data_read), 0);
        check_eq("rst_addr", 32'(flash_if.avmm_data_addr), 0);
        r0 = nreads;
        reset_n = 1'b1;
        wait_ready("load_ready", 300);
        check_eq("load_blank", 32'(blank), 0);
        check_eq("load_reads", 32'(nreads - r0), 9);
        read_cfg(3'd3, d); check_eq("load_idx3", d, 32'h4);
        read_cfg(3'd0, d); check_eq("load_idx0", d, 32'h1);
        read_cfg(3'd7, d); check_eq("load_idx7", d, 32'h8);

        // Waitrequest stretching; save pulse during load is dropped
        wait_n = 5;
        r0 = nreads; e0 = nerase;
        do_reset(0);
        repeat (10) @(negedge clock);
        pulse_save();
        wait_ready("wr_ready", 600);
        check_eq("wr_stable", 32'(stable_err), 0);
        check_eq("wr_reads", 32'(nreads - r0), 9);
        read_cfg(3'd5, d); check_eq("wr_idx5", d, 32'h6);
        repeat (30) @(negedge clock);
        check_eq("load_save_ign", 32'(nerase - e0), 0);
        check_eq("load_save_rdy", 32'(ready), 1);
        wait_n = 0;

        // Erased flash
        r0 = nreads;
        do_reset(1);
        wait_ready("blank_ready", 300);
        check_eq("blank_flag", 32'(blank), 1);
        check_eq("blank_reads", 32'(nreads - r0), 1);
        for (int i = 0; i < 8; i++) begin
            read_cfg(3'(i), d);
            check_eq($sformatf("blank_idx%0d", i), d, 0);
        end

        // Save after a cache update
        do_reset(0);
        wait_ready("save_load", 300);
        @(negedge clock) begin cfg_idx = 3'd2; cfg_wdata = 32'hABCD; cfg_we = 1'b1; end
        @(negedge clock) cfg_we = 1'b0;
        read_cfg(3'd2, d); check_eq("save_cache2", d, 32'hABCD);
        w0 = nwrites; e0 = nerase;
        pulse_save();
        check_eq("save_busy", 32'(ready), 0);
        wait_ready("save_ready", 1500);
        check_eq("save_erases", 32'(nerase - e0), 1);
        check_eq("save_sector", 32'(erase_sector), 1);
        check_eq("save_eword", erase_word, 32'hFF1F_FFFF);
        check_eq("save_writes", 32'(nwrites - w0), 9);
        check_eq("save_magic", mem[0], MAGIC);
        check_eq("save_w1", mem[1], 32'h1);
        check_eq("save_w3", mem[3], 32'hABCD);
        check_eq("save_w8", mem[8], 32'h8);
        check_eq("save_prot", last_ctrl, 32'hFFFF_FFFF);
        check_eq("save_error", 32'(error), 0);
        check_eq("save_stable", 32'(stable_err), 0);

        // Erase failure, then error clears on next save
        erase_ok_cfg = 1'b0;
        w0 = nwrites;
        pulse_save();
        wait_ready("efail_ready", 1000);
        check_eq("efail_error", 32'(error), 1);
        check_eq("efail_writes", 32'(nwrites - w0), 0);
        check_eq("efail_prot", last_ctrl, 32'hFFFF_FFFF);
        erase_ok_cfg = 1'b1;
        w0 = nwrites;
        pulse_save();
        check_eq("eclr_error", 32'(error), 0);
        wait_ready("eclr_ready", 1500);
        check_eq("eclr_writes", 32'(nwrites - w0), 9);
        check_eq("eclr_error2", 32'(error), 0);

        // Status stuck busy exhausts the poll limit
        stuck_busy = 1'b1;
        w0 = nwrites;
        pulse_save();
        wait_ready("plim_ready", 1000);
        stuck_busy = 1'b0;
        check_eq("plim_error", 32'(error), 1);
        check_eq("plim_writes", 32'(nwrites - w0), 0);
        check_eq("csr_rd_addr", 32'(csr_bad), 0);

        // Reset while programming the first word
        pulse_save();
        n = 0;
        while (!flash_if.avmm_data_write && n < 500) begin
            @(negedge clock);
            n++;
        end
        check_eq("abort_prog", 32'(flash_if.avmm_data_write), 1);
        stuck_busy = 1'b1;
        repeat (10) @(negedge clock);
        img_mode = 2;
        reset_n  = 1'b0;
        repeat (2) @(negedge clock);
        check_eq("abort_ready", 32'(ready), 0);
        check_eq("abort_error", 32'(error), 0);
        check_eq("abort_wr", 32'(flash_if.avmm_data_write), 0);
        check_eq("abort_csrrd", 32'(flash_if.avmm_csr_read), 0);
        check_eq("abort_addr", 32'(flash_if.avmm_data_addr), 0);
        check_eq("abort_rdata", cfg_rdata, 0);
        stuck_busy = 1'b0;
        reset_n    = 1'b1;
        n = 0;
        while (!flash_if.avmm_data_read && n < 10) begin
            @(negedge clock);
            n++;
        end
        check_eq("reload_rd", 32'(flash_if.avmm_data_read), 1);
        check_eq("reload_addr", 32'(flash_if.avmm_data_addr), 0);
        wait_ready("reload_ready", 300);
        check_eq("reload_blank", 32'(blank), 1);
        read_cfg(3'd3, d); check_eq("reload_idx3", d, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
